aes_key_sched_ctrl: RTL and testbench

- Iterative, clocked AES key-schedule controller. Generates one expanded-key word per cycle through a single shared SubWord unit and stores all 4*(Nr+1) words in an internal word array.
- Serves 128-bit round keys to two requesters, the encrypt core and the decrypt core, through a round-robin read arbiter with fixed 1-cycle response latency.
- Replaces the combinational full-unroll expansion on timing-critical builds.

---
 rtl/aes_pkg.sv | 48 ++++
 rtl/aes_sub_word.sv | 13 +
 rtl/aes_key_sched_ctrl.sv | 151 +++++++++++++++
 tb/tb_aes_key_sched_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES helpers: S-box, GF(2^8) doubling, legal key sizes and key-schedule states.
// Pure declarations; no timing or flow control involved.
package aes_pkg;

    localparam int NB    = 4;
    localparam int NK128 = 4;
    localparam int NR128 = 10;
    localparam int NK192 = 6;
    localparam int NR192 = 12;
    localparam int NK256 = 8;
    localparam int NR256 = 14;

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} ksState_t;

    // Row-major S-box, entry 0x00 in the top byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[(255 - int'(b)) * 8 +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic legalPair(input int nk, input int nr);
        return (nk == NK128 && nr == NR128) || (nk == NK192 && nr == NR192) ||
               (nk == NK256 && nr == NR256);
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: four parallel S-box lookups on a 32-bit word.
// Purely combinational, zero latency, no flow control.
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] wordIn,
    output logic [31:0] wordOut
);

    assign wordOut = {sbox(wordIn[31:24]), sbox(wordIn[23:16]),
                      sbox(wordIn[15:8]),  sbox(wordIn[7:0])};

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES key schedule (one word per cycle) with a round-robin enc/dec round-key read port.
// Schedule ready 4*(Nr+1)-Nk+1 cycles after key accept; reads answer 1 cycle after grant, requesters hold until granted.
module aes_key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_valid,
    input  logic [Nk*32-1:0] key_in,
    output logic             key_ready,
    output logic             busy,
    output logic             keys_valid,
    input  logic             enc_req,
    input  logic [3:0]       enc_round,
    input  logic             dec_req,
    input  logic [3:0]       dec_round,
    output logic             enc_gnt,
    output logic             dec_gnt,
    output logic             rk_valid,
    output logic             rk_id,
    output logic [127:0]     rk_data,
    output logic             rk_err
);

    localparam int NWORDS = NB * (Nr + 1);
    localparam int IW     = 6;

    logic [31:0]   wArr [NWORDS];
    ksState_t      state;
    logic [IW-1:0] wIdx;
    logic [2:0]    kPos;
    logic [7:0]    rcon;
    logic          prioDec;

    logic          accept;
    logic [31:0]   prevWord, backWord, subIn, subOut, tWord, newWord;
    logic          encWin, decWin;
    logic [3:0]    reqRound;
    logic          roundErr;
    logic [IW-1:0] baseIdx;

    assign accept = key_valid & key_ready;

    always_comb begin
        prevWord = wArr[wIdx - IW'(1)];
        backWord = wArr[wIdx - IW'(Nk)];
        subIn    = (kPos == 3'd0) ? {prevWord[23:0], prevWord[31:24]} : prevWord;
    end

    aes_sub_word u_subWord (
        .wordIn (subIn),
        .wordOut(subOut)
    );

    always_comb begin
        if (kPos == 3'd0)
            tWord = subOut ^ {rcon, 24'h0};
        else if (Nk == 8 && kPos == 3'd4)
            tWord = subOut;
        else
            tWord = prevWord;
        newWord = backWord ^ tWord;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            key_ready  <= 1'b1;
            busy       <= 1'b0;
            keys_valid <= 1'b0;
            wIdx       <= '0;
            kPos       <= '0;
            rcon       <= 8'h01;
        end else begin
            case (state)
                IDLE, DONE: begin
                    // DONE entry is the last-word edge, so keys_valid lands one cycle later.
                    if (state == DONE)
                        keys_valid <= 1'b1;
                    if (accept) begin
                        state      <= EXPAND;
                        key_ready  <= 1'b0;
                        busy       <= 1'b1;
                        keys_valid <= 1'b0;
                        wIdx       <= IW'(Nk);
                        kPos       <= '0;
                        rcon       <= 8'h01;
                    end
                end
                EXPAND: begin
                    wIdx <= wIdx + IW'(1);
                    kPos <= (kPos == 3'(Nk - 1)) ? 3'd0 : kPos + 3'd1;
                    if (kPos == 3'd0)
                        rcon <= xtime(rcon);
                    if (wIdx == IW'(NWORDS - 1)) begin
                        state     <= DONE;
                        key_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < Nk; k++)
                wArr[k] <= key_in[(Nk - 1 - k) * 32 +: 32];
        end else if (state == EXPAND) begin
            wArr[wIdx] <= newWord;
        end
    end

    always_comb begin
        encWin   = keys_valid & enc_req & (~dec_req | ~prioDec);
        decWin   = keys_valid & dec_req & (~enc_req | prioDec);
        reqRound = decWin ? dec_round : enc_round;
        roundErr = reqRound > 4'(Nr);
        // Clamp so an out-of-range round never indexes past the word array.
        baseIdx  = roundErr ? '0 : {reqRound, 2'b00};
    end

    assign enc_gnt = encWin;
    assign dec_gnt = decWin;

    always_ff @(posedge clk) begin
        if (reset) begin
            rk_valid <= 1'b0;
            rk_id    <= 1'b0;
            rk_err   <= 1'b0;
            rk_data  <= '0;
            prioDec  <= 1'b0;
        end else begin
            rk_valid <= encWin | decWin;
            if (encWin | decWin) begin
                rk_id   <= decWin;
                rk_err  <= roundErr;
                rk_data <= roundErr ? 128'h0 :
                           {wArr[baseIdx], wArr[baseIdx + IW'(1)],
                            wArr[baseIdx + IW'(2)], wArr[baseIdx + IW'(3)]};
            end
            if (keys_valid & enc_req & dec_req)
                prioDec <= ~prioDec;
        end
    end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench: AES-128/192/256 schedules, arbitration, reload and mid-expansion reset.
module tb_aes_key_sched_ctrl;

    localparam logic [127:0] K1    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] R1    = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] R2    = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] R3    = 128'h3d80477d4716fe3e1e237e446d7a883b;
    localparam logic [127:0] R10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K2    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [191:0] K192  = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [127:0] R192  = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] R256  = 128'h24fc79ccbf0979e9371ac23c6d68de36;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic         kv0, kr0, busy0, kvs0, encReq0, decReq0, encGnt0, decGnt0, rkV0, rkId0, rkErr0;
    logic [127:0] key0, rkD0;
    logic [3:0]   encRnd0, decRnd0;
    logic         kv1, kr1, busy1, kvs1, encReq1, decReq1, encGnt1, decGnt1, rkV1, rkId1, rkErr1;
    logic [191:0] key1;
    logic [127:0] rkD1;
    logic [3:0]   encRnd1, decRnd1;
    logic         kv2, kr2, busy2, kvs2, encReq2, decReq2, encGnt2, decGnt2, rkV2, rkId2, rkErr2;
    logic [255:0] key2;
    logic [127:0] rkD2;
    logic [3:0]   encRnd2, decRnd2;

    aes_key_sched_ctrl #(.Nk(4), .Nr(10)) dut0 (
        .clk(clk), .reset(reset), .key_valid(kv0), .key_in(key0), .key_ready(kr0),
        .busy(busy0), .keys_valid(kvs0), .enc_req(encReq0), .enc_round(encRnd0),
        .dec_req(decReq0), .dec_round(decRnd0), .enc_gnt(encGnt0), .dec_gnt(decGnt0),
        .rk_valid(rkV0), .rk_id(rkId0), .rk_data(rkD0), .rk_err(rkErr0));

    aes_key_sched_ctrl #(.Nk(6), .Nr(12)) dut1 (
        .clk(clk), .reset(reset), .key_valid(kv1), .key_in(key1), .key_ready(kr1),
        .busy(busy1), .keys_valid(kvs1), .enc_req(encReq1), .enc_round(encRnd1),
        .dec_req(decReq1), .dec_round(decRnd1), .enc_gnt(encGnt1), .dec_gnt(decGnt1),
        .rk_valid(rkV1), .rk_id(rkId1), .rk_data(rkD1), .rk_err(rkErr1));

    aes_key_sched_ctrl #(.Nk(8), .Nr(14)) dut2 (
        .clk(clk), .reset(reset), .key_valid(kv2), .key_in(key2), .key_ready(kr2),
        .busy(busy2), .keys_valid(kvs2), .enc_req(encReq2), .enc_round(encRnd2),
        .dec_req(decReq2), .dec_round(decRnd2), .enc_gnt(encGnt2), .dec_gnt(decGnt2),
        .rk_valid(rkV2), .rk_id(rkId2), .rk_data(rkD2), .rk_err(rkErr2));

    typedef struct {
        logic         side;
        logic [3:0]   rnd;
        logic         expErr;
        logic [127:0] expData;
    } vec_t;

    vec_t vecs [8];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chkInt(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Entered #1 after the accepting edge; counts edges until keys_valid is seen.
    task automatic waitKeys(input int expLat, input bit pulse, input bit inflight,
                            input logic [127:0] oldData);
        int n = 0;
        int grants = 0;
        while (kvs0 !== 1'b1 && n < 200) begin
            @(negedge clk);
            grants += int'(encGnt0 | decGnt0);
            if (inflight && n == 0) begin
                chk1("inflight_rk_valid", rkV0, 1'b1);
                chk128("inflight_old_key", rkD0, oldData);
            end
            if (n == 1) begin
                chk1("busy_expand", busy0, 1'b1);
                chk1("key_ready_expand", kr0, 1'b0);
            end
            if (pulse && n == 10) begin
                kv0  = 1'b1;
                key0 = ~key0;
            end
            if (pulse && n == 11)
                kv0 = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        chkInt("latency128", n, expLat);
        chkInt("grants_during_expand", grants, 0);
    endtask

    task automatic heldGrant(input logic side, input logic [127:0] expData);
        @(negedge clk);
        chk1("held_gnt", side ? decGnt0 : encGnt0, 1'b1);
        @(posedge clk);
        #1;
        encReq0 = 1'b0;
        decReq0 = 1'b0;
        @(negedge clk);
        chk1("held_rk_valid", rkV0, 1'b1);
        chk1("held_rk_id", rkId0, side);
        chk128("held_rk_data", rkD0, expData);
    endtask

    task automatic oneReq(input logic side, input logic [3:0] rnd, input logic expErr,
                          input logic [127:0] expData);
        @(posedge clk);
        #1;
        if (side) begin
            decReq0 = 1'b1;
            decRnd0 = rnd;
        end else begin
            encReq0 = 1'b1;
            encRnd0 = rnd;
        end
        @(negedge clk);
        chk1("vec_enc_gnt", encGnt0, ~side);
        chk1("vec_dec_gnt", decGnt0, side);
        @(posedge clk);
        #1;
        encReq0 = 1'b0;
        decReq0 = 1'b0;
        @(negedge clk);
        chk1("vec_rk_valid", rkV0, 1'b1);
        chk1("vec_rk_id", rkId0, side);
        chk1("vec_rk_err", rkErr0, expErr);
        chk128("vec_rk_data", rkD0, expData);
    endtask

    task automatic runTable();
        for (int v = 0; v < 8; v++)
            oneReq(vecs[v].side, vecs[v].rnd, vecs[v].expErr, vecs[v].expData);
    endtask

    initial begin
        int n;
        int lat1;
        int lat2;

        vecs[0] = '{1'b0, 4'd0,  1'b0, K1};
        vecs[1] = '{1'b0, 4'd1,  1'b0, R1};
        vecs[2] = '{1'b1, 4'd2,  1'b0, R2};
        vecs[3] = '{1'b1, 4'd3,  1'b0, R3};
        vecs[4] = '{1'b0, 4'd10, 1'b0, R10};
        vecs[5] = '{1'b1, 4'd10, 1'b0, R10};
        vecs[6] = '{1'b0, 4'd15, 1'b1, 128'h0};
        vecs[7] = '{1'b1, 4'd11, 1'b1, 128'h0};

        reset = 1'b1;
        kv0 = 1'b0; key0 = '0; encReq0 = 1'b0; decReq0 = 1'b1; encRnd0 = '0; decRnd0 = 4'd1;
        kv1 = 1'b0; key1 = K192; encReq1 = 1'b0; decReq1 = 1'b0; encRnd1 = '0; decRnd1 = '0;
        kv2 = 1'b0; key2 = K256; encReq2 = 1'b0; decReq2 = 1'b0; encRnd2 = '0; decRnd2 = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state, with a decrypt request already pending.
        @(negedge clk);
        chk1("rst_key_ready", kr0, 1'b1);
        chk1("rst_busy", busy0, 1'b0);
        chk1("rst_keys_valid", kvs0, 1'b0);
        chk1("rst_dec_gnt", decGnt0, 1'b0);
        chk1("rst_rk_valid", rkV0, 1'b0);
        chk1("rst_rk_err", rkErr0, 1'b0);
        chk128("rst_rk_data", rkD0, 128'h0);

        // AES-128 load with an ignored key_valid pulse; held dec request waits for keys_valid.
        @(posedge clk);
        #1;
        kv0  = 1'b1;
        key0 = K1;
        @(posedge clk);
        #1;
        kv0 = 1'b0;
        waitKeys(41, 1'b1, 1'b0, 128'h0);
        heldGrant(1'b1, R1);
        runTable();

        // Simultaneous requests alternate starting from enc.
        @(posedge clk);
        #1;
        encReq0 = 1'b1; encRnd0 = 4'd1;
        decReq0 = 1'b1; decRnd0 = 4'd10;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk1("arb_enc_gnt", encGnt0, k % 2 == 0);
            chk1("arb_dec_gnt", decGnt0, k % 2 == 1);
            if (k > 0) begin
                chk1("arb_rk_id", rkId0, (k - 1) % 2 == 1);
                chk128("arb_rk_data", rkD0, ((k - 1) % 2 == 1) ? R10 : R1);
            end
        end
        @(posedge clk);
        #1;
        encReq0 = 1'b0;
        decReq0 = 1'b0;
        @(negedge clk);
        chk1("arb_last_rk_id", rkId0, 1'b1);
        chk128("arb_last_rk_data", rkD0, R10);

        // Reload in DONE while a round-0 read is granted in the same cycle.
        @(posedge clk);
        #1;
        kv0 = 1'b1; key0 = K2;
        encReq0 = 1'b1; encRnd0 = 4'd0;
        @(negedge clk);
        chk1("reload_gnt", encGnt0, 1'b1);
        @(posedge clk);
        #1;
        kv0 = 1'b0;
        chk1("reload_keys_valid_drop", kvs0, 1'b0);
        waitKeys(41, 1'b0, 1'b1, K1);
        heldGrant(1'b0, K2);
        oneReq(1'b0, 4'd10, 1'b0, K2R10);

        // Reset at cycle 20 of EXPAND, then a fresh key.
        @(posedge clk);
        #1;
        kv0 = 1'b1; key0 = K1;
        @(posedge clk);
        #1;
        kv0 = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk1("midrst_key_ready", kr0, 1'b1);
        chk1("midrst_busy", busy0, 1'b0);
        chk1("midrst_keys_valid", kvs0, 1'b0);
        @(posedge clk);
        #1;
        kv0 = 1'b1; key0 = K1;
        @(posedge clk);
        #1;
        kv0 = 1'b0;
        waitKeys(41, 1'b0, 1'b0, 128'h0);
        runTable();

        // AES-192 and AES-256 loaded together.
        @(posedge clk);
        #1;
        kv1 = 1'b1;
        kv2 = 1'b1;
        @(posedge clk);
        #1;
        kv1 = 1'b0;
        kv2 = 1'b0;
        n = 0; lat1 = -1; lat2 = -1;
        while ((lat1 < 0 || lat2 < 0) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (lat1 < 0 && kvs1 === 1'b1) lat1 = n;
            if (lat2 < 0 && kvs2 === 1'b1) lat2 = n;
        end
        chkInt("latency192", lat1, 47);
        chkInt("latency256", lat2, 53);
        encReq1 = 1'b1; encRnd1 = 4'd12;
        decReq2 = 1'b1; decRnd2 = 4'd14;
        @(negedge clk);
        chk1("gnt192", encGnt1, 1'b1);
        chk1("gnt256", decGnt2, 1'b1);
        @(posedge clk);
        #1;
        encReq1 = 1'b0;
        decReq2 = 1'b0;
        @(negedge clk);
        chk1("rk_valid192", rkV1, 1'b1);
        chk128("rk_data192_r12", rkD1, R192);
        chk1("rk_id256", rkId2, 1'b1);
        chk128("rk_data256_r14", rkD2, R256);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
